operand2_fetch: RTL

Multi-cycle front stage for the data-processing second operand: accepts an instruction and the current C flag, reads Rm and optionally Rs from the register file, and decodes the shifter-operand field. It drives the combinational `shift_unit` directly with a registered, stable operand, type, amount and carry-in. Encoding corner cases (#0 forms, register shift by 0, ROR by multiples of 32) are resolved here so the shift unit only sees cases it handles correctly.

---
 rtl/operand2_fetch.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/operand2_fetch.sv
// Second-operand front stage: fetches Rm/Rs from the register file and decodes the
// shifter-operand field into a stable, registered bundle for the shift unit.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// S_IDLE    | ready for a new instruction
// S_RM_WAIT | Rm read data arriving; register-shift forms also issue the Rs read
// S_RS_WAIT | Rs read data arriving; register-shift bundle is built here
// S_OUT     | bundle valid and held until downstream accepts it
module operand2_fetch (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_instr,
   input  logic        i_cflag,
   input  logic [31:0] i_pc,
   output logic [3:0]  o_rf_raddr,
   input  logic [31:0] i_rf_rdata,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_op,
   output logic [2:0]  o_type,
   output logic [7:0]  o_amount,
   output logic        o_carry
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RM_WAIT = 2'd1,
      S_RS_WAIT = 2'd2,
      S_OUT     = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] op;
      logic [2:0]  ty;
      logic [7:0]  amt;
      logic        c;
   } bundle_t;

   localparam logic [2:0] T_ROR = 3'd3;
   localparam logic [2:0] T_RRX = 3'd4;
   localparam logic [2:0] T_BYP = 3'd7;

   state_t      state_q;
   logic [11:0] instr_q;
   logic        cflag_q;
   logic [31:0] rm_q;
   logic [3:0]  raddr_q;
   logic        valid_q;
   bundle_t     out_q;

   bundle_t     imm_b;
   bundle_t     ish_b;
   bundle_t     rsh_b;
   logic [31:0] pc12;
   logic [31:0] rm_live;
   logic [7:0]  rs_amt;
   logic [3:0]  rot;
   logic [4:0]  imm5;
   logic [1:0]  sh;

   logic        unused_instr_bits;
   assign unused_instr_bits = ^{i_instr[31:26], i_instr[24:12]};

   // PC reads see the pipeline offset: +8 normally, +12 when a register shift is involved
   always_comb begin
      pc12    = i_pc + 32'd12;
      rm_live = i_rf_rdata;
      if (instr_q[3:0] == 4'hF) begin
         rm_live = instr_q[4] ? pc12 : (i_pc + 32'd8);
      end
      rs_amt = (instr_q[11:8] == 4'hF) ? pc12[7:0] : i_rf_rdata[7:0];
      sh     = instr_q[6:5];
      imm5   = instr_q[11:7];
   end

   always_comb begin
      rot       = i_instr[11:8];
      imm_b.op  = {24'd0, i_instr[7:0]};
      imm_b.c   = i_cflag;
      imm_b.ty  = T_ROR;
      imm_b.amt = {3'd0, rot, 1'b0};
      if (rot == 4'd0) begin
         imm_b.ty  = T_BYP;
         imm_b.amt = 8'd0;
      end
   end

   // #0 encodings: LSR/ASR #0 mean a 32-bit shift, ROR #0 means RRX
   always_comb begin
      ish_b.op  = rm_live;
      ish_b.c   = cflag_q;
      ish_b.ty  = {1'b0, sh};
      ish_b.amt = {3'd0, imm5};
      if (imm5 == 5'd0) begin
         case (sh)
            2'd1, 2'd2: ish_b.amt = 8'd32;
            2'd3: begin
               ish_b.ty  = T_RRX;
               ish_b.amt = 8'd0;
            end
            default: ish_b.amt = 8'd0;
         endcase
      end
   end

   // ROR by a nonzero multiple of 32 leaves the value unchanged but carries out bit 31
   always_comb begin
      rsh_b.op  = rm_q;
      rsh_b.c   = cflag_q;
      rsh_b.ty  = {1'b0, sh};
      rsh_b.amt = rs_amt;
      if (rs_amt == 8'd0) begin
         rsh_b.ty  = T_BYP;
         rsh_b.amt = 8'd0;
      end else if ((sh == 2'd3) && (rs_amt[4:0] == 5'd0)) begin
         rsh_b.ty  = T_BYP;
         rsh_b.amt = 8'd0;
         rsh_b.c   = rm_q[31];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         instr_q <= 12'd0;
         cflag_q <= 1'b0;
         rm_q    <= 32'd0;
         raddr_q <= 4'd0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else if (i_flush) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_valid) begin
                  instr_q <= i_instr[11:0];
                  cflag_q <= i_cflag;
                  if (i_instr[25]) begin
                     out_q   <= imm_b;
                     valid_q <= 1'b1;
                     state_q <= S_OUT;
                  end else begin
                     raddr_q <= i_instr[3:0];
                     state_q <= S_RM_WAIT;
                  end
               end
            end
            S_RM_WAIT: begin
               rm_q <= rm_live;
               if (instr_q[4]) begin
                  raddr_q <= instr_q[11:8];
                  state_q <= S_RS_WAIT;
               end else begin
                  out_q   <= ish_b;
                  valid_q <= 1'b1;
                  state_q <= S_OUT;
               end
            end
            S_RS_WAIT: begin
               out_q   <= rsh_b;
               valid_q <= 1'b1;
               state_q <= S_OUT;
            end
            S_OUT: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_ready    = (state_q == S_IDLE);
   assign o_valid    = valid_q;
   assign o_rf_raddr = raddr_q;
   assign o_op       = out_q.op;
   assign o_type     = out_q.ty;
   assign o_amount   = out_q.amt;
   assign o_carry    = out_q.c;

endmodule
